// File: rtl/muxnx1_rr_arbiter.sv
// rtl/muxnx1_rr_arbiter.sv - round-robin arbiter driving the select of a shared muxnx1 datapath
// Grants one requester at a time for at most MAX_HOLD cycles, with one idle cycle between owners.
module muxnx1_rr_arbiter #(
   parameter int SIZE     = 16,
   parameter int MAX_HOLD = 8,
   localparam int SEL_W   = $clog2(SIZE)
) (
   input  logic             muxnx1_rr_arbiter_port_clk,
   input  logic             muxnx1_rr_arbiter_port_rst_n,
   input  logic [SIZE-1:0]  muxnx1_rr_arbiter_port_req,
   output logic [SIZE-1:0]  muxnx1_rr_arbiter_port_grant,
   output logic [SEL_W-1:0] muxnx1_rr_arbiter_port_sel,
   output logic             muxnx1_rr_arbiter_port_valid
);

   localparam int HC_W = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
   localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(SIZE - 1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [SIZE-1:0]  grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [HC_W-1:0]  hold_q, hold_d;
   logic [SEL_W-1:0] last_ptr_q, last_ptr_d;

   logic             scan_found;
   logic [SEL_W-1:0] scan_winner;
   logic [SEL_W-1:0] scan_cand;
   int               scan_idx;
   logic             owner_req;

   // Search starts just past the previous owner, so it is the last one considered.
   always_comb begin
      scan_found  = 1'b0;
      scan_winner = '0;
      scan_cand   = '0;
      scan_idx    = 0;
      for (int k = 1; k <= SIZE; k++) begin
         scan_idx  = (int'(last_ptr_q) + k) % SIZE;
         scan_cand = SEL_W'(scan_idx);
         if (!scan_found && muxnx1_rr_arbiter_port_req[scan_cand]) begin
            scan_found  = 1'b1;
            scan_winner = scan_cand;
         end
      end
   end

   assign owner_req = muxnx1_rr_arbiter_port_req[sel_q];

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      valid_d    = valid_q;
      hold_d     = hold_q;
      last_ptr_d = last_ptr_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            valid_d = 1'b0;
            if (scan_found) begin
               grant_d[scan_winner] = 1'b1;
               sel_d      = scan_winner;
               valid_d    = 1'b1;
               last_ptr_d = scan_winner;
               hold_d     = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (owner_req && (hold_q < HOLD_LAST)) begin
               hold_d = hold_q + HC_W'(1);
            end else begin
               // sel is left on the old owner so the downstream mux stays stable.
               grant_d = '0;
               valid_d = 1'b0;
               hold_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge muxnx1_rr_arbiter_port_clk) begin
      if (!muxnx1_rr_arbiter_port_rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         sel_q      <= '0;
         valid_q    <= 1'b0;
         hold_q     <= '0;
         last_ptr_q <= PTR_RESET;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         hold_q     <= hold_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   assign muxnx1_rr_arbiter_port_grant = grant_q;
   assign muxnx1_rr_arbiter_port_sel   = sel_q;
   assign muxnx1_rr_arbiter_port_valid = valid_q;

endmodule

// File: tb/tb_muxnx1_rr_arbiter.sv
// tb/tb_muxnx1_rr_arbiter.sv - self-checking bench for muxnx1_rr_arbiter (SIZE=16, MAX_HOLD=8)
module tb_muxnx1_rr_arbiter;

   localparam int SIZE     = 16;
   localparam int MAX_HOLD = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] grant;
   logic [3:0]  sel;
   logic        valid;

   int n_checks = 0;
   int n_errors = 0;

   muxnx1_rr_arbiter #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
      .muxnx1_rr_arbiter_port_clk   (clk),
      .muxnx1_rr_arbiter_port_rst_n (rst_n),
      .muxnx1_rr_arbiter_port_req   (req),
      .muxnx1_rr_arbiter_port_grant (grant),
      .muxnx1_rr_arbiter_port_sel   (sel),
      .muxnx1_rr_arbiter_port_valid (valid)
   );

   always #5 clk = ~clk;

   // Reference: owner index (-1 when idle), cycles held so far, last winner.
   int m_owner, m_sel, m_last, m_cnt;

   function automatic void model_step(input logic r_n, input logic [15:0] r);
      bit found;
      int idx;
      if (!r_n) begin
         m_owner = -1; m_sel = 0; m_last = SIZE - 1; m_cnt = 0;
      end else if (m_owner < 0) begin
         found = 0;
         for (int k = 1; k <= SIZE; k++) begin
            idx = (m_last + k) % SIZE;
            if (!found && r[idx]) begin
               found = 1; m_owner = idx; m_sel = idx; m_last = idx; m_cnt = 1;
            end
         end
      end else if (r[m_owner] && m_cnt < MAX_HOLD) begin
         m_cnt++;
      end else begin
         m_owner = -1;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model with the current inputs, then compare after the edge.
   task automatic tick();
      logic [15:0] exp_grant;
      model_step(rst_n, req);
      @(posedge clk);
      #1;
      exp_grant = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
      check("model_grant", {16'h0, grant}, {16'h0, exp_grant});
      check("model_sel", {28'h0, sel}, m_sel);
      check("model_valid", {31'h0, valid}, {31'h0, (m_owner >= 0)});
      check("onehot", $countones(grant) <= 1, 1);
      if (valid) check("sel_matches_grant", {16'h0, grant}, {16'h0, 16'h1 << sel});
   endtask

   typedef struct {
      logic        rst_n;
      logic [15:0] req;
      logic [15:0] exp_grant;
      logic [3:0]  exp_sel;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int exp_owner, run_len;
      logic prev_valid;

      rst_n = 1'b0;
      req   = 16'hFFFF;

      vecs[0]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0};
      vecs[1]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0};
      vecs[2]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0};
      vecs[3]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1};
      vecs[4]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1};
      vecs[5]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1};
      vecs[6]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1};
      vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 4'd3, 1'b0};
      vecs[8]  = '{1'b1, 16'h0000, 16'h0000, 4'd3, 1'b0};
      vecs[9]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1};
      vecs[10] = '{1'b1, 16'h0010, 16'h0000, 4'd3, 1'b0};
      vecs[11] = '{1'b1, 16'h0010, 16'h0010, 4'd4, 1'b1};

      for (int i = 0; i < 12; i++) begin
         rst_n = vecs[i].rst_n;
         req   = vecs[i].req;
         tick();
         check($sformatf("vec%0d_grant", i), {16'h0, grant}, {16'h0, vecs[i].exp_grant});
         check($sformatf("vec%0d_sel", i), {28'h0, sel}, {28'h0, vecs[i].exp_sel});
         check($sformatf("vec%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
      end

      // Full rotation with every requester asking: 0..15 then 0, each for 8 cycles.
      rst_n = 1'b0; req = 16'hFFFF; tick();
      rst_n = 1'b1;
      exp_owner = 0; run_len = 0; prev_valid = 1'b0;
      for (int c = 0; c < 17 * 9; c++) begin
         tick();
         if (valid && !prev_valid) begin
            check("rotation_owner", {28'h0, sel}, exp_owner);
            exp_owner = (exp_owner + 1) % SIZE;
         end
         if (!valid && prev_valid) check("rotation_hold_len", run_len, MAX_HOLD);
         run_len    = valid ? run_len + 1 : 0;
         prev_valid = valid;
      end
      check("rotation_count", exp_owner, 1);

      // Wrap-around: after 15 is served, 0 wins, then 15.
      rst_n = 1'b0; req = 16'h0; tick();
      rst_n = 1'b1; req = 16'h8000; tick();
      check("wrap_g15", {16'h0, grant}, 32'h8000);
      req = 16'h0; tick(); tick();
      req = 16'h8001; tick();
      check("wrap_g0", {16'h0, grant}, 32'h0001);
      for (int c = 0; c < 7; c++) tick();
      check("wrap_hold_end", {16'h0, grant}, 32'h0001);
      tick();
      check("wrap_gap", {31'h0, valid}, 0);
      tick();
      check("wrap_g15_again", {16'h0, grant}, 32'h8000);

      // Reset in the 4th cycle of a grant to index 5.
      rst_n = 1'b0; req = 16'h0; tick();
      rst_n = 1'b1; req = 16'h0020;
      for (int c = 0; c < 4; c++) tick();
      check("mid_grant5", {16'h0, grant}, 32'h0020);
      rst_n = 1'b0; req = 16'h0021; tick();
      check("midrst_grant", {16'h0, grant}, 0);
      check("midrst_valid", {31'h0, valid}, 0);
      check("midrst_sel", {28'h0, sel}, 0);
      rst_n = 1'b1; tick();
      check("midrst_next", {16'h0, grant}, 32'h0001);

      // Non-owner bits toggling during a grant to index 2 are ignored.
      rst_n = 1'b0; req = 16'h0; tick();
      rst_n = 1'b1; req = 16'h0004; tick();
      for (int c = 0; c < 7; c++) begin
         req = (c % 2 == 0) ? 16'h00F4 : 16'h0004;
         tick();
         check("toggle_grant", {16'h0, grant}, 32'h0004);
         check("toggle_sel", {28'h0, sel}, 2);
      end
      req = 16'h00F0; tick();
      check("toggle_release", {31'h0, valid}, 0);
      tick();
      check("toggle_next", {16'h0, grant}, 32'h0010);

      // Random traffic against the reference model, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         case ($urandom_range(0, 3))
            0: req = 16'($urandom);
            1: req = 16'h1 << $urandom_range(0, 15);
            2: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: req = (c % 3 == 0) ? 16'h0 : 16'hFFFF;
         endcase
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
